// File: rtl/pp_sequencer.sv
// Initiator side of the neuron potential-processing handshake: issues one
// start_pp* per time unit, collects per-neuron completions, and runs WTA.
module pp_sequencer #(
  parameter int N     = 8,
  parameter int W     = 32,
  parameter int T_SIM = 350,
  parameter int TU_W  = 9,
  localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             img_start,
  input  logic             learn_en,
  input  logic             in_active,
  input  logic [N-1:0]     valid_pp1,
  input  logic [N-1:0]     valid_pp2,
  input  logic [N-1:0]     valid_pp3m,
  input  logic [N-1:0]     valid_pp3,
  input  logic [N-1:0]     spike_pp,
  input  logic [N*W-1:0]   potential,
  output logic             start_core_img,
  output logic             start_pp1,
  output logic             start_pp2,
  output logic             start_pp3,
  output logic             start_pp3m,
  output logic [N-1:0]     won_lost_hold,
  output logic             TU_incre,
  output logic [TU_W-1:0]  tu_count,
  output logic [N-1:0]     spike_out,
  output logic [IDW-1:0]   winner_id,
  output logic             img_done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_P  = 3'd2,
    ARGMAX  = 3'd3,
    ISSUE_M = 3'd4,
    WAIT_3  = 3'd5,
    TU_END  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    K_P1 = 2'd0,
    K_P2 = 2'd1,
    K_P3 = 2'd2
  } kind_t;

  state_t                state, state_nx;
  kind_t                 kind;
  logic                  learn;
  logic [N-1:0]          mask;
  logic [N-1:0]          vsel;
  logic [N-1:0]          mask_acc;
  logic [N-1:0]          mask3_acc;
  logic [N-1:0]          spk_cap;
  logic [IDW-1:0]        arg_idx;
  logic [IDW-1:0]        best_idx;
  logic signed [W-1:0]   best;
  logic signed [W-1:0]   cand;
  logic                  last_tu;
  logic                  arg_last;

  assign state_dbg = state;
  assign last_tu   = (tu_count == TU_W'(T_SIM - 1));
  assign arg_last  = (arg_idx == IDW'(N - 1));
  assign cand      = $signed(potential[int'(arg_idx)*W +: W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Completion uses this cycle's valids too, so the last responder is not delayed.
  always_comb begin
    vsel      = '0;
    state_nx  = state;
    case (kind)
      K_P1:    vsel = valid_pp1;
      K_P2:    vsel = valid_pp2;
      default: vsel = valid_pp3m;
    endcase
    mask_acc  = mask | vsel;
    mask3_acc = mask | valid_pp3;
    case (state)
      IDLE:    if (img_start) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT_P;
      WAIT_P:  if (&mask_acc) state_nx = (kind == K_P3) ? ARGMAX : TU_END;
      ARGMAX:  if (arg_last) state_nx = ISSUE_M;
      ISSUE_M: state_nx = WAIT_3;
      WAIT_3:  if (&mask3_acc) state_nx = TU_END;
      TU_END:  state_nx = last_tu ? IDLE : ISSUE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_core_img <= 1'b0;
      start_pp1      <= 1'b0;
      start_pp2      <= 1'b0;
      start_pp3      <= 1'b0;
      start_pp3m     <= 1'b0;
      won_lost_hold  <= '0;
      TU_incre       <= 1'b0;
      tu_count       <= '0;
      spike_out      <= '0;
      winner_id      <= '0;
      img_done       <= 1'b0;
      kind           <= K_P1;
      learn          <= 1'b0;
      mask           <= '0;
      spk_cap        <= '0;
      arg_idx        <= '0;
      best_idx       <= '0;
      best           <= '0;
    end else begin
      start_core_img <= 1'b0;
      start_pp1      <= 1'b0;
      start_pp2      <= 1'b0;
      start_pp3      <= 1'b0;
      start_pp3m     <= 1'b0;
      TU_incre       <= 1'b0;
      img_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (img_start) begin
            start_core_img <= 1'b1;
            learn          <= learn_en;
            tu_count       <= '0;
          end
        end
        ISSUE: begin
          mask    <= '0;
          spk_cap <= '0;
          arg_idx <= '0;
          if (!in_active) begin
            kind      <= K_P1;
            start_pp1 <= 1'b1;
          end else if (!learn) begin
            kind      <= K_P2;
            start_pp2 <= 1'b1;
          end else begin
            kind      <= K_P3;
            start_pp3 <= 1'b1;
          end
        end
        WAIT_P: begin
          mask <= mask_acc;
          if (kind == K_P2) begin
            for (int i = 0; i < N; i++)
              if (valid_pp2[i]) spk_cap[i] <= spike_pp[i];
          end
        end
        ARGMAX: begin
          // Strict greater-than keeps the lowest index on ties.
          arg_idx <= arg_idx + IDW'(1);
          if (arg_idx == '0 || cand > best) begin
            best     <= cand;
            best_idx <= arg_idx;
          end
        end
        ISSUE_M: begin
          won_lost_hold <= N'(1) << best_idx;
          start_pp3m    <= 1'b1;
          mask          <= '0;
          winner_id     <= best_idx;
        end
        WAIT_3: begin
          mask <= mask3_acc;
          for (int i = 0; i < N; i++)
            if (valid_pp3[i]) spk_cap[i] <= spike_pp[i];
          if (&mask3_acc) won_lost_hold <= '0;
        end
        TU_END: begin
          spike_out <= spk_cap;
          TU_incre  <= 1'b1;
          if (last_tu) img_done <= 1'b1;
          else         tu_count <= tu_count + TU_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_sequencer.sv
// Directed-plus-random bench for pp_sequencer: the bench plays the N neurons
// and predicts TU count, captured spikes and WTA winner from first principles.
module tb_pp_sequencer;
  localparam int N     = 8;
  localparam int W     = 32;
  localparam int T_SIM = 4;
  localparam int TU_W  = 3;
  localparam int IDW   = $clog2(N);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             img_start = 1'b0;
  logic             learn_en = 1'b0;
  logic             in_active = 1'b0;
  logic [N-1:0]     valid_pp1 = '0;
  logic [N-1:0]     valid_pp2 = '0;
  logic [N-1:0]     valid_pp3m = '0;
  logic [N-1:0]     valid_pp3 = '0;
  logic [N-1:0]     spike_pp = '0;
  logic [N*W-1:0]   potential;
  logic             start_core_img, start_pp1, start_pp2, start_pp3, start_pp3m;
  logic [N-1:0]     won_lost_hold;
  logic             TU_incre;
  logic [TU_W-1:0]  tu_count;
  logic [N-1:0]     spike_out;
  logic [IDW-1:0]   winner_id;
  logic             img_done;
  logic [2:0]       state_dbg;

  int pot_v[N];
  int n_cmp = 0;
  int n_err = 0;
  int exp_tu = 0;
  bit learn_m = 1'b0;
  int tu_seen = 0;
  int cnt_core = 0, cnt_p1 = 0, cnt_p2 = 0, cnt_p3 = 0, cnt_p3m = 0;

  pp_sequencer #(.N(N), .W(W), .T_SIM(T_SIM), .TU_W(TU_W)) dut (
    .clk(clk), .rst_n(rst_n), .img_start(img_start), .learn_en(learn_en),
    .in_active(in_active), .valid_pp1(valid_pp1), .valid_pp2(valid_pp2),
    .valid_pp3m(valid_pp3m), .valid_pp3(valid_pp3), .spike_pp(spike_pp),
    .potential(potential), .start_core_img(start_core_img), .start_pp1(start_pp1),
    .start_pp2(start_pp2), .start_pp3(start_pp3), .start_pp3m(start_pp3m),
    .won_lost_hold(won_lost_hold), .TU_incre(TU_incre), .tu_count(tu_count),
    .spike_out(spike_out), .winner_id(winner_id), .img_done(img_done),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  always_comb begin
    potential = '0;
    for (int i = 0; i < N; i++) potential[W*i +: W] = pot_v[i];
  end

  // Pulse counters: each edge counts the level held over the preceding cycle.
  always @(posedge clk) begin
    cnt_core <= cnt_core + int'(start_core_img);
    cnt_p1   <= cnt_p1 + int'(start_pp1);
    cnt_p2   <= cnt_p2 + int'(start_pp2);
    cnt_p3   <= cnt_p3 + int'(start_pp3);
    cnt_p3m  <= cnt_p3m + int'(start_pp3m);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rnd_n();
    logic [31:0] r;
    r = $urandom;
    return r[N-1:0];
  endfunction

  function automatic int ref_winner();
    int b;
    b = 0;
    for (int i = 1; i < N; i++) if (pot_v[i] > pot_v[b]) b = i;
    return b;
  endfunction

  task automatic rand_pots();
    int j;
    for (int i = 0; i < N; i++) pot_v[i] = int'($urandom) >>> $urandom_range(0, 12);
    if ($urandom_range(0, 1) == 1) begin
      j = ref_winner();
      pot_v[$urandom_range(0, N-1)] = pot_v[j];
    end
  endtask

  // which: 1 valid_pp1, 2 valid_pp2, 3 valid_pp3m, 4 valid_pp3
  task automatic drive_valids(input int which, input logic [N-1:0] spk, input bit stray,
                              input logic [N-1:0] hold_exp);
    int d[N];
    int i9;
    logic [N-1:0] v, sp;
    for (int i = 0; i < N; i++) d[i] = $urandom_range(1, 9);
    i9 = $urandom_range(0, N-1);
    d[i9] = 9;
    d[(i9 + 1) % N] = 1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk("no_early_tu", TU_incre, 0);
      if (which == 4) chk("wl_hold_stable", won_lost_hold, hold_exp);
      v = '0;
      for (int i = 0; i < N; i++) if (d[i] == k) v[i] = 1'b1;
      sp = rnd_n();
      for (int i = 0; i < N; i++) if (v[i]) sp[i] = spk[i];
      spike_pp   = sp;
      valid_pp1  = (which == 1) ? v : '0;
      valid_pp2  = (which == 2) ? v : '0;
      valid_pp3m = (which == 3) ? v : '0;
      valid_pp3  = (which == 4) ? v : '0;
      img_start  = 1'b0;
      if (stray && k == 1) begin
        img_start = 1'b1;
        valid_pp3 = rnd_n() | N'(1);
      end
    end
    @(negedge clk);
    valid_pp1 = '0; valid_pp2 = '0; valid_pp3m = '0; valid_pp3 = '0;
    img_start = 1'b0;
    spike_pp  = rnd_n();
  endtask

  task automatic start_img(input bit l);
    @(negedge clk);
    img_start = 1'b1;
    learn_en  = l;
    learn_m   = l;
    exp_tu    = 0;
    @(negedge clk);
    img_start = 1'b0;
    learn_en  = $urandom_range(0, 1);
    chk("core_img_pulse", start_core_img, 1);
    chk("tu_cleared", tu_count, 0);
  endtask

  task automatic run_tu(input bit ia, input logic [N-1:0] spk, input bit stray, input bit rst_mid);
    int kind, win;
    bit seen, exp_done;
    int b1, b2, b3, b3m, bc;
    logic [N-1:0] exp_spk, hold;
    kind = !ia ? 1 : (learn_m ? 3 : 2);
    in_active = ia;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (start_pp1 | start_pp2 | start_pp3) begin seen = 1'b1; break; end
    end
    chk("start_seen", seen, 1);
    if (!seen) return;
    chk("start_kind", {start_pp3, start_pp2, start_pp1}, 64'(1) << (kind - 1));
    b1 = cnt_p1; b2 = cnt_p2; b3 = cnt_p3; b3m = cnt_p3m; bc = cnt_core;
    in_active = $urandom_range(0, 1);
    hold = '0;
    if (kind == 1) begin
      drive_valids(1, spk, 1'b0, hold);
      exp_spk = '0;
    end else if (kind == 2) begin
      drive_valids(2, spk, stray, hold);
      exp_spk = spk;
    end else begin
      drive_valids(3, rnd_n(), 1'b0, hold);
      win = ref_winner();
      hold[win] = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < N + 8; c++) begin
        @(negedge clk);
        if (start_pp3m) begin seen = 1'b1; break; end
      end
      chk("pp3m_seen", seen, 1);
      if (!seen) return;
      chk("wl_onehot", won_lost_hold, hold);
      chk("winner_id", winner_id, win);
      if (rst_mid) begin
        rst_n = 1'b0;
        #1;
        chk("rst_pulses", {start_core_img, start_pp1, start_pp2, start_pp3, start_pp3m,
                           TU_incre, img_done}, 0);
        chk("rst_wl", won_lost_hold, 0);
        chk("rst_tu_count", tu_count, 0);
        chk("rst_spike_out", spike_out, 0);
        chk("rst_winner", winner_id, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        b1 = cnt_p1; b2 = cnt_p2; b3 = cnt_p3; b3m = cnt_p3m; bc = cnt_core;
        repeat (4) @(negedge clk);
        chk("no_start_after_rst", (cnt_p1 - b1) + (cnt_p2 - b2) + (cnt_p3 - b3) +
                                  (cnt_p3m - b3m) + (cnt_core - bc), 0);
        return;
      end
      drive_valids(4, spk, 1'b0, hold);
      exp_spk = spk;
    end
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (TU_incre) begin seen = 1'b1; break; end
    end
    chk("tu_incre_seen", seen, 1);
    if (!seen) return;
    tu_seen++;
    exp_done = (exp_tu == T_SIM - 1);
    if (!exp_done) exp_tu++;
    chk("tu_count", tu_count, exp_tu);
    chk("img_done", img_done, exp_done);
    chk("spike_out", spike_out, exp_spk);
    chk("wl_cleared", won_lost_hold, 0);
    chk("pp3m_once", cnt_p3m - b3m, (kind == 3) ? 1 : 0);
    chk("single_start", (cnt_p1 - b1) + (cnt_p2 - b2) + (cnt_p3 - b3), 1);
    chk("no_core_in_tu", cnt_core - bc, 0);
  endtask

  initial begin
    int b1, b2, b3, b3m, bc, t0;
    for (int i = 0; i < N; i++) pot_v[i] = 0;
    repeat (3) @(negedge clk);
    chk("reset_pulses", {start_core_img, start_pp1, start_pp2, start_pp3, start_pp3m,
                         TU_incre, img_done}, 0);
    chk("reset_vectors", {won_lost_hold, spike_out, tu_count, winner_id}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_quiet", {start_core_img, start_pp1, start_pp2, start_pp3, start_pp3m, TU_incre}, 0);

    // decay-only TUs, then the image's last TU
    start_img(1'b0);
    b1 = cnt_p1; b2 = cnt_p2; b3 = cnt_p3; b3m = cnt_p3m; t0 = tu_seen;
    repeat (3) run_tu(1'b0, rnd_n(), 1'b0, 1'b0);
    chk("t1_pp1_count", cnt_p1 - b1, 3);
    chk("t1_other_starts", (cnt_p2 - b2) + (cnt_p3 - b3) + (cnt_p3m - b3m), 0);
    chk("t1_tu_incre_count", tu_seen - t0, 3);
    chk("t1_tu_count", tu_count, 3);
    run_tu(1'b1, rnd_n(), 1'b0, 1'b0);
    chk("t4_done_with_last_incre", {img_done, TU_incre}, 2'b11);
    b1 = cnt_p1; b2 = cnt_p2; b3 = cnt_p3; b3m = cnt_p3m; bc = cnt_core;
    repeat (5) @(negedge clk);
    chk("t4_idle_after_img", (cnt_p1 - b1) + (cnt_p2 - b2) + (cnt_p3 - b3) +
                             (cnt_p3m - b3m) + (cnt_core - bc), 0);
    chk("t4_tu_held", tu_count, T_SIM - 1);

    // integrate+fire with skewed responses, stray pulses in one TU
    start_img(1'b0);
    run_tu(1'b1, 8'b0000_0100, 1'b0, 1'b0);
    run_tu(1'b1, rnd_n(), 1'b1, 1'b0);
    run_tu(1'(($urandom_range(0, 1))), rnd_n(), 1'b0, 1'b0);
    run_tu(1'b1, rnd_n(), 1'b0, 1'b0);

    // winner-take-all
    start_img(1'b1);
    pot_v[0] = 5 * 4096;  pot_v[1] = 9 * 4096; pot_v[2] = 9 * 4096; pot_v[3] = -3 * 4096;
    pot_v[4] = 0;         pot_v[5] = 1 * 4096; pot_v[6] = 2 * 4096; pot_v[7] = 4 * 4096;
    run_tu(1'b1, rnd_n(), 1'b0, 1'b0);
    chk("t3_winner_fixed", winner_id, 1);
    rand_pots();
    run_tu(1'b1, rnd_n(), 1'b0, 1'b0);
    run_tu(1'b0, rnd_n(), 1'b0, 1'b0);
    for (int i = 0; i < N; i++) pot_v[i] = -1000 - i;
    run_tu(1'b1, rnd_n(), 1'b0, 1'b0);

    // reset during the decision phase, then a clean image
    start_img(1'b1);
    rand_pots();
    run_tu(1'b1, rnd_n() | N'(1), 1'b0, 1'b0);
    rand_pots();
    pot_v[N-1] = 32'h7fff_ffff;
    run_tu(1'b1, rnd_n(), 1'b0, 1'b1);
    start_img(1'b0);
    repeat (T_SIM) run_tu(1'(($urandom_range(0, 1))), rnd_n(), 1'b0, 1'b0);

    // random images
    for (int m = 0; m < 3; m++) begin
      start_img(1'(($urandom_range(0, 1))));
      for (int t = 0; t < T_SIM; t++) begin
        rand_pots();
        run_tu(1'(($urandom_range(0, 3) != 0)), rnd_n(), 1'(($urandom_range(0, 1))), 1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
